// File: rtl/vdc_ram_sched_if.sv
// Bundle of requester, refresh-control and RAM-port signals around the VDC video-RAM scheduler.
// slave: the scheduler side; master: the requesters and the RAM.
interface vdc_ram_sched_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  logic          ramsize;
  logic          line_start;
  logic [3:0]    drr;

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic          disp_rvalid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;

  logic          blk_req;
  logic          blk_we;
  logic [AW-1:0] blk_addr;
  logic [DW-1:0] blk_wdata;
  logic          blk_ack;
  logic          blk_rvalid;

  logic          ram_en;
  logic          ram_we;
  logic          ram_refresh;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;
  logic [DW-1:0] rdata;
  logic [4:0]    ref_pending;

  modport slave (
    input  ramsize, line_start, drr,
    input  disp_req, disp_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  blk_req, blk_we, blk_addr, blk_wdata,
    input  ram_do,
    output disp_ack, disp_rvalid, cpu_ack, cpu_rvalid, blk_ack, blk_rvalid,
    output ram_en, ram_we, ram_refresh, ram_addr, ram_di, rdata, ref_pending
  );

  modport master (
    output ramsize, line_start, drr,
    output disp_req, disp_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output blk_req, blk_we, blk_addr, blk_wdata,
    output ram_do,
    input  disp_ack, disp_rvalid, cpu_ack, cpu_rvalid, blk_ack, blk_rvalid,
    input  ram_en, ram_we, ram_refresh, ram_addr, ram_di, rdata, ref_pending
  );
endinterface

// File: rtl/vdc_ram_sched.sv
// Video-RAM port scheduler: display > refresh > CPU/block round-robin, with refresh debt
// accounting, 16k/64k address aliasing and a tagged read-return pipeline.
module vdc_ram_sched #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  vdc_ram_sched_if.slave   bus
);
  localparam int unsigned DEBT_W = 5;
  localparam int unsigned ROW_W  = 8;
  localparam logic [DEBT_W:0] DEBT_MAX = (DEBT_W+1)'(31);

  typedef enum logic [2:0] {G_NONE, G_DISP, G_REF, G_CPU, G_BLK} grant_e;
  typedef enum logic [1:0] {T_NONE, T_DISP, T_CPU, T_BLK} tag_e;

  grant_e            grant_c;
  tag_e              tag_c;
  tag_e              tag1;
  tag_e              tag2;
  logic              we_c;
  logic              cpu_ok_c;
  logic              blk_ok_c;
  logic              rr_blk;
  logic [AW-1:0]     addr_c;
  logic [DW-1:0]     wdata_c;
  logic [DEBT_W-1:0] debt;
  logic [DEBT_W:0]   debt_sum_c;
  logic [DEBT_W-1:0] debt_next_c;
  logic [ROW_W-1:0]  row;

  // Arbitration; a requester acked this cycle is masked so it cannot win back-to-back.
  always_comb begin
    grant_c  = G_NONE;
    cpu_ok_c = bus.cpu_req && !bus.cpu_ack;
    blk_ok_c = bus.blk_req && !bus.blk_ack;
    if (bus.disp_req && !bus.disp_ack)  grant_c = G_DISP;
    else if (debt != '0)                grant_c = G_REF;
    else if (cpu_ok_c && blk_ok_c)      grant_c = rr_blk ? G_BLK : G_CPU;
    else if (cpu_ok_c)                  grant_c = G_CPU;
    else if (blk_ok_c)                  grant_c = G_BLK;
  end

  // Address, write data and read-owner tag of the winning requester.
  always_comb begin
    addr_c  = bus.ram_addr;
    wdata_c = bus.ram_di;
    we_c    = 1'b0;
    tag_c   = T_NONE;
    case (grant_c)
      G_DISP: begin addr_c = bus.disp_addr; tag_c = T_DISP; end
      G_REF:  addr_c = AW'(row);
      G_CPU: begin
        addr_c  = bus.cpu_addr;
        wdata_c = bus.cpu_wdata;
        we_c    = bus.cpu_we;
        tag_c   = bus.cpu_we ? T_NONE : T_CPU;
      end
      G_BLK: begin
        addr_c  = bus.blk_addr;
        wdata_c = bus.blk_wdata;
        we_c    = bus.blk_we;
        tag_c   = bus.blk_we ? T_NONE : T_BLK;
      end
      default: ;
    endcase
    if (!bus.ramsize) addr_c[AW-1 -: 2] = 2'b00;
  end

  // Refresh debt: line additions and a granted refresh both land in the same cycle, clipped at 31.
  always_comb begin
    debt_sum_c  = (DEBT_W+1)'(debt)
                + (bus.line_start ? (DEBT_W+1)'(bus.drr) : '0)
                - ((grant_c == G_REF) ? (DEBT_W+1)'(1) : '0);
    debt_next_c = (debt_sum_c > DEBT_MAX) ? DEBT_W'(DEBT_MAX) : debt_sum_c[DEBT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.disp_ack    <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.blk_ack     <= 1'b0;
      bus.disp_rvalid <= 1'b0;
      bus.cpu_rvalid  <= 1'b0;
      bus.blk_rvalid  <= 1'b0;
      bus.ram_en      <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_refresh <= 1'b0;
      bus.ram_addr    <= '0;
      bus.ram_di      <= '0;
      bus.rdata       <= '0;
      rr_blk          <= 1'b0;
      debt            <= '0;
      row             <= '0;
      tag1            <= T_NONE;
      tag2            <= T_NONE;
    end else begin
      bus.disp_ack    <= (grant_c == G_DISP);
      bus.cpu_ack     <= (grant_c == G_CPU);
      bus.blk_ack     <= (grant_c == G_BLK);
      bus.ram_en      <= (grant_c != G_NONE);
      bus.ram_we      <= we_c;
      bus.ram_refresh <= (grant_c == G_REF);
      if (grant_c != G_NONE) bus.ram_addr <= addr_c;
      if (grant_c == G_CPU || grant_c == G_BLK) bus.ram_di <= wdata_c;
      if (grant_c == G_REF) row <= row + ROW_W'(1);
      if (grant_c == G_CPU) rr_blk <= 1'b1;
      if (grant_c == G_BLK) rr_blk <= 1'b0;
      debt <= debt_next_c;
      // ram_do is valid one cycle after ram_en; the second tag stage lines up with it.
      tag1            <= tag_c;
      tag2            <= tag1;
      bus.disp_rvalid <= (tag2 == T_DISP);
      bus.cpu_rvalid  <= (tag2 == T_CPU);
      bus.blk_rvalid  <= (tag2 == T_BLK);
      if (tag2 != T_NONE) bus.rdata <= bus.ram_do;
    end
  end

  assign bus.ref_pending = debt;
endmodule
